// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter for sequence-detector stimulus.
// A frame is requested over a valid/ready handshake. The latched pattern is sent
// MSB first and repeated max(repeat_cnt,1) times. An optional idle gap separates
// consecutive instances. Each instance's last bit is flagged with pat_end, and the
// end of the frame is marked by a one-cycle frame_done pulse.
`timescale 1ns/1ps
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             pat_end,
  output logic             frame_done,
  output logic             busy
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [GAP_W-1:0] r_gap_len;
  logic [CNT_W-1:0] r_rep;      // instances still owed, including the one on the wire
  logic [GAP_W-1:0] r_gap_cnt;
  logic [IDX_W-1:0] r_bit_idx;  // index of the bit currently driven on x_out
  logic             r_x_out;
  logic             r_x_valid;
  logic             r_pat_end;
  logic             r_frame_done;

  logic             w_accept;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_rep_load;

  assign start_ready = (r_state == S_IDLE) & ~rst;
  assign busy        = (r_state != S_IDLE);
  assign x_out       = r_x_out;
  assign x_valid     = r_x_valid;
  assign pat_end     = r_pat_end;
  assign frame_done  = r_frame_done;

  assign w_accept   = start_valid & start_ready & ~abort;
  assign w_idx_nxt  = r_bit_idx - IDX_W'(1);
  assign w_rep_load = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;

  // Capture the frame payload on accept; it is held untouched for the whole frame.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pat     <= pattern;
      r_gap_len <= gap_len;
    end
  end

  // Frame sequencer: serializes bits, inserts gaps, and produces registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rep        <= '0;
      r_gap_cnt    <= '0;
      r_bit_idx    <= '0;
      r_x_out      <= 1'b0;
      r_x_valid    <= 1'b0;
      r_pat_end    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_x_out   <= 1'b0;
          r_x_valid <= 1'b0;
          r_pat_end <= 1'b0;
          if (w_accept) begin
            // First bit comes straight from the input so it appears one cycle after accept.
            r_rep     <= w_rep_load;
            r_bit_idx <= IDX_MSB;
            r_x_out   <= pattern[PAT_W-1];
            r_x_valid <= 1'b1;
            r_state   <= S_SEND;
          end
        end

        S_SEND: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_pat_end <= 1'b0;
          end else if (r_bit_idx == '0) begin
            if (r_rep <= CNT_W'(1)) begin
              // Final instance finished: no trailing gap, pulse frame_done.
              r_state      <= S_IDLE;
              r_x_out      <= 1'b0;
              r_x_valid    <= 1'b0;
              r_pat_end    <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_rep <= r_rep - CNT_W'(1);
              if (r_gap_len != '0) begin
                r_state   <= S_GAP;
                r_gap_cnt <= r_gap_len;
                r_x_out   <= 1'b0;
                r_x_valid <= 1'b0;
                r_pat_end <= 1'b0;
              end else begin
                // Back-to-back restart with no bubble.
                r_bit_idx <= IDX_MSB;
                r_x_out   <= r_pat[PAT_W-1];
                r_x_valid <= 1'b1;
                r_pat_end <= 1'b0;
              end
            end
          end else begin
            r_bit_idx <= w_idx_nxt;
            r_x_out   <= r_pat[w_idx_nxt];
            r_x_valid <= 1'b1;
            r_pat_end <= (w_idx_nxt == '0);
          end
        end

        S_GAP: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_pat_end <= 1'b0;
          end else if (r_gap_cnt <= GAP_W'(1)) begin
            r_state   <= S_SEND;
            r_bit_idx <= IDX_MSB;
            r_x_out   <= r_pat[PAT_W-1];
            r_x_valid <= 1'b1;
            r_pat_end <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_x_out   <= 1'b0;
          r_x_valid <= 1'b0;
          r_pat_end <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: directed frames from the test plan followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
`timescale 1ns/1ps
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic             abort = 1'b0;
  logic             x_out;
  logic             x_valid;
  logic             pat_end;
  logic             frame_done;
  logic             busy;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .abort      (abort),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .pat_end    (pat_end),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: one queue entry per remaining frame cycle; front is the current cycle.
  typedef struct packed {
    logic v;
    logic x;
    logic pe;
  } ent_t;

  ent_t q[$];
  logic m_done = 1'b0;

  task automatic build_frame(input logic [PAT_W-1:0] p, input int rep, input int gap);
    int r_tot;
    ent_t e;
    r_tot = (rep == 0) ? 1 : rep;
    for (int r = 0; r < r_tot; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        e.v  = 1'b1;
        e.x  = p[b];
        e.pe = (b == 0);
        q.push_back(e);
      end
      if (r < r_tot - 1) begin
        for (int g = 0; g < gap; g++) begin
          e = '0;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_cycle();
    ent_t e;
    e = '0;
    if (q.size() != 0) e = q[0];
    chk("x_valid", x_valid, e.v);
    chk("x_out", x_out, e.x);
    chk("pat_end", pat_end, e.pe);
    chk("frame_done", frame_done, m_done);
    chk("busy", busy, q.size() != 0);
    chk("start_ready", start_ready, q.size() == 0);
  endtask

  // One clock cycle: check the current outputs, drive inputs for the next edge,
  // and advance the model across that edge.
  task automatic step(input logic sv, input logic [PAT_W-1:0] p, input int rep,
                      input int gap, input logic ab);
    @(negedge clk);
    check_cycle();
    start_valid = sv;
    pattern     = p;
    repeat_cnt  = CNT_W'(rep);
    gap_len     = GAP_W'(gap);
    abort       = ab;
    if (q.size() != 0) begin
      m_done = 1'b0;
      if (ab) begin
        q.delete();
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (sv && !ab) build_frame(p, rep, gap);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 0, 0, 1'b0);
  endtask

  initial begin
    // Reset state while rst is held.
    #1;
    chk("rst_x_valid", x_valid, 1'b0);
    chk("rst_x_out", x_out, 1'b0);
    chk("rst_pat_end", pat_end, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start_ready", start_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single instance, no gap.
    step(1'b1, 4'b1010, 1, 0, 1'b0);
    idle(7);
    // Three back-to-back instances.
    step(1'b1, 4'b1010, 3, 0, 1'b0);
    idle(15);
    // Two instances with a two-cycle gap.
    step(1'b1, 4'b1010, 2, 2, 1'b0);
    idle(13);
    // repeat_cnt=0 with start_valid held: re-accept in the frame_done cycle.
    for (int i = 0; i < 14; i++) step(1'b1, 4'b0110, 0, 0, 1'b0);
    idle(6);
    // Abort during cycle 2 of a three-instance frame.
    step(1'b1, 4'b1010, 3, 0, 1'b0);
    step(1'b0, '0, 0, 0, 1'b0);
    step(1'b0, '0, 0, 0, 1'b1);
    idle(4);
    // Start coincident with abort in IDLE is blocked.
    step(1'b1, 4'b1111, 1, 0, 1'b1);
    idle(4);
    // Abort during a gap.
    step(1'b1, 4'b1001, 3, 3, 1'b0);
    idle(5);
    step(1'b0, '0, 0, 0, 1'b1);
    idle(3);

    // Asynchronous reset pulse between edges during cycle 3 of SEND.
    step(1'b1, 4'b1010, 3, 0, 1'b0);
    idle(3);
    #1 rst = 1'b1;
    #1;
    chk("arst_x_valid", x_valid, 1'b0);
    chk("arst_pat_end", pat_end, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_frame_done", frame_done, 1'b0);
    chk("arst_start_ready", start_ready, 1'b0);
    #1 rst = 1'b0;
    q.delete();
    m_done = 1'b0;
    #1;
    chk("arst_ready_after", start_ready, 1'b1);
    step(1'b1, 4'b1100, 2, 1, 1'b0);
    idle(12);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic sv;
      logic ab;
      int   rep;
      int   gap;
      sv  = ($urandom_range(0, 2) == 0);
      ab  = ($urandom_range(0, 40) == 0);
      rep = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 5));
      gap = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      step(sv, PAT_W'($urandom), rep, gap, ab);
    end
    start_valid = 1'b0;
    abort       = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
